// File: rtl/knapsack_search_ctrl_if.sv
// Handshake and checker-datapath bundle between the system sequencer, the
// knapsack search controller and the external combinational constraint checker.
interface knapsack_search_ctrl_if #(
  parameter int unsigned N_ITEMS = 6,
  parameter int unsigned VAL_W   = 6
);
  logic               start;
  logic               abort;
  logic               first_only;
  logic [N_ITEMS-1:0] cand;
  logic               chk_valid;
  logic [VAL_W-1:0]   chk_value;
  logic               busy;
  logic               done;
  logic               found;
  logic [N_ITEMS-1:0] best_mask;
  logic [VAL_W-1:0]   best_value;
  logic [N_ITEMS:0]   feas_count;

  modport master (
    output start, abort, first_only, chk_valid, chk_value,
    input  cand, busy, done, found, best_mask, best_value, feas_count
  );

  modport slave (
    input  start, abort, first_only, chk_valid, chk_value,
    output cand, busy, done, found, best_mask, best_value, feas_count
  );
endinterface

// File: rtl/knapsack_search_ctrl.sv
// Exhaustive mask enumerator for the knapsack checker: one candidate per cycle,
// tracks the best feasible mask (ties keep the lower mask) and the feasible count.
module knapsack_search_ctrl #(
  parameter int unsigned N_ITEMS = 6,
  parameter int unsigned VAL_W   = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  knapsack_search_ctrl_if.slave bus
);
  localparam logic [N_ITEMS-1:0] LastMask = '1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_ITEMS-1:0] cand_q, cand_d;
  logic               found_q, found_d;
  logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
  logic [VAL_W-1:0]   best_value_q, best_value_d;
  logic [N_ITEMS:0]   feas_count_q, feas_count_d;
  logic               first_only_q, first_only_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cand_q       <= '0;
      found_q      <= 1'b0;
      best_mask_q  <= '0;
      best_value_q <= '0;
      feas_count_q <= '0;
      first_only_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      found_q      <= found_d;
      best_mask_q  <= best_mask_d;
      best_value_q <= best_value_d;
      feas_count_q <= feas_count_d;
      first_only_q <= first_only_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    found_d      = found_q;
    best_mask_d  = best_mask_q;
    best_value_d = best_value_q;
    feas_count_d = feas_count_q;
    first_only_d = first_only_q;

    unique case (state_q)
      StIdle: begin
        cand_d = '0;
        // start beats a simultaneous abort; previous results held until here
        if (bus.start) begin
          state_d      = StScan;
          found_d      = 1'b0;
          best_mask_d  = '0;
          best_value_d = '0;
          feas_count_d = '0;
          first_only_d = bus.first_only;
        end
      end
      StScan: begin
        if (bus.abort) begin
          // the sample taken in the abort cycle is discarded along with all results
          state_d      = StIdle;
          cand_d       = '0;
          found_d      = 1'b0;
          best_mask_d  = '0;
          best_value_d = '0;
          feas_count_d = '0;
        end else begin
          if (bus.chk_valid) begin
            if (!found_q || (bus.chk_value > best_value_q)) begin
              best_mask_d  = cand_q;
              best_value_d = bus.chk_value;
              found_d      = 1'b1;
            end
            feas_count_d = feas_count_q + 1'b1;
          end
          if ((cand_q == LastMask) || (first_only_q && bus.chk_valid)) begin
            state_d = StDone;
          end else begin
            cand_d = cand_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.cand       = cand_q;
  assign bus.busy       = (state_q == StScan);
  assign bus.done       = (state_q == StDone);
  assign bus.found      = found_q;
  assign bus.best_mask  = best_mask_q;
  assign bus.best_value = best_value_q;
  assign bus.feas_count = feas_count_q;
endmodule

// File: tb/tb_knapsack_search_ctrl.sv
// Bench for knapsack_search_ctrl: vector table of fixed checkers, randomized
// checker tables against a scan model, plus reset and abort sequences.
module tb_knapsack_search_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   errors = 0;
  int   checks = 0;

  bit         rnd_valid [64];
  logic [5:0] rnd_value [64];

  always #5 clk = ~clk;

  knapsack_search_ctrl_if #(.N_ITEMS(6), .VAL_W(6)) kif ();

  knapsack_search_ctrl #(.N_ITEMS(6), .VAL_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  // Production triple-constraint checker
  function automatic bit prod_ok(input int m);
    int val[6] = '{4, 2, 2, 1, 10, 20};
    int wgt[6] = '{12, 1, 2, 1, 4, 1};
    int vol[6] = '{10, 2, 1, 4, 3, 12};
    int cst[6] = '{3, 2, 1, 3, 2, 1};
    int sv = 0, sw = 0, so = 0, sc = 0;
    for (int i = 0; i < 6; i++) begin
      if (m[i]) begin
        sv += val[i]; sw += wgt[i]; so += vol[i]; sc += cst[i];
      end
    end
    return (sv >= 15) && (sw <= 16) && (so <= 10) && (sc <= 10);
  endfunction

  function automatic int prod_val(input int m);
    int val[6] = '{4, 2, 2, 1, 10, 20};
    int sv = 0;
    for (int i = 0; i < 6; i++) if (m[i]) sv += val[i];
    return sv;
  endfunction

  function automatic bit chk_ok(input int md, input int m);
    case (md)
      0:       return prod_ok(m);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return rnd_valid[m];
    endcase
  endfunction

  function automatic int chk_val(input int md, input int m);
    case (md)
      0:       return prod_val(m);
      1:       return 5;
      2:       return 63;
      default: return int'(rnd_value[m]);
    endcase
  endfunction

  always_comb begin
    kif.chk_valid = chk_ok(mode, int'(kif.cand));
    kif.chk_value = 6'(chk_val(mode, int'(kif.cand)));
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs_packed();
    return int'({kif.busy, kif.done, kif.found, kif.cand, kif.best_mask, kif.best_value,
                 kif.feas_count});
  endfunction

  function automatic int results_packed();
    return int'({kif.found, kif.best_mask, kif.best_value, kif.feas_count});
  endfunction

  // Reference: walk all masks in order, keep the strictly-greater best value
  task automatic model_scan(input int md, input bit fo, output int f, output int m,
                            output int v, output int c, output int lat);
    f = 0; m = 0; v = 0; c = 0; lat = 65;
    for (int k = 0; k < 64; k++) begin
      if (chk_ok(md, k)) begin
        c++;
        if (f == 0 || chk_val(md, k) > v) begin
          f = 1; m = k; v = chk_val(md, k);
        end
        if (fo) begin
          lat = k + 2;
          break;
        end
      end
    end
  endtask

  task automatic run_scan(input string nm, input int md, input bit fo, input bit ab,
                          input int inj, input int ef, input int em, input int ev,
                          input int ec, input int elat);
    int j, cand_err, extra_done, stray_busy, exp_res;
    mode = md;
    @(negedge clk);
    kif.start = 1'b1; kif.first_only = fo; kif.abort = ab;
    @(negedge clk);
    kif.start = 1'b0; kif.first_only = 1'b0; kif.abort = 1'b0;
    j = 1; cand_err = 0;
    while (j <= 200 && !kif.done) begin
      if (!kif.busy || kif.cand != 6'(j - 1)) cand_err++;
      kif.start = (inj > 0) && (j == inj - 1);
      @(negedge clk);
      j++;
    end
    kif.start = 1'b0;
    exp_res = int'({ef[0], em[5:0], ev[5:0], ec[6:0]});
    check({nm, " done_cycle"}, j, elat);
    check({nm, " cand_seq_errs"}, cand_err, 0);
    check({nm, " busy_at_done"}, int'(kif.busy), 0);
    check({nm, " found"}, int'(kif.found), ef);
    check({nm, " best_mask"}, int'(kif.best_mask), em);
    check({nm, " best_value"}, int'(kif.best_value), ev);
    check({nm, " feas_count"}, int'(kif.feas_count), ec);
    extra_done = 0; stray_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (kif.done) extra_done++;
      if (kif.busy) stray_busy++;
    end
    check({nm, " extra_done"}, extra_done, 0);
    check({nm, " busy_after"}, stray_busy, 0);
    check({nm, " idle_cand"}, int'(kif.cand), 0);
    check({nm, " results_held"}, results_packed(), exp_res);
  endtask

  typedef struct {
    string nm;
    int    mode;
    bit    fo;
    bit    abort_too;
    int    inject_at;
    int    found;
    int    mask;
    int    value;
    int    count;
    int    lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int f, m, v, c, lat, waited, saw_done;
    vecs[0] = '{"prod_full",      0, 1'b0, 1'b0, 0,  1, 30, 15, 1,  65};
    vecs[1] = '{"prod_first",     0, 1'b1, 1'b0, 0,  1, 30, 15, 1,  32};
    vecs[2] = '{"all_valid_tie",  1, 1'b0, 1'b0, 0,  1, 0,  5,  64, 65};
    vecs[3] = '{"none_valid",     2, 1'b0, 1'b0, 0,  0, 0,  0,  0,  65};
    vecs[4] = '{"start_abort",    0, 1'b0, 1'b1, 0,  1, 30, 15, 1,  65};
    vecs[5] = '{"start_in_scan",  1, 1'b0, 1'b0, 10, 1, 0,  5,  64, 65};
    vecs[6] = '{"first_mask0",    1, 1'b1, 1'b0, 0,  1, 0,  5,  1,  2};

    mode = 2;
    rst_n = 1'b0;
    kif.start = 1'b0; kif.abort = 1'b0; kif.first_only = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_packed(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs_packed(), 0);

    for (int i = 0; i < 7; i++) begin
      run_scan(vecs[i].nm, vecs[i].mode, vecs[i].fo, vecs[i].abort_too, vecs[i].inject_at,
               vecs[i].found, vecs[i].mask, vecs[i].value, vecs[i].count, vecs[i].lat);
    end

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 64; k++) begin
        rnd_valid[k] = ($urandom_range(0, 3) == 0);
        rnd_value[k] = (r < 4) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      end
      model_scan(3, r[0], f, m, v, c, lat);
      run_scan($sformatf("rand%0d", r), 3, r[0], 1'b0, 0, f, m, v, c, lat);
    end

    // Abort at cand=20 with every mask feasible, so results are non-zero before abort
    mode = 1;
    @(negedge clk);
    kif.start = 1'b1;
    @(negedge clk);
    kif.start = 1'b0;
    waited = 0;
    while (waited < 100 && !(kif.busy && kif.cand == 6'd20)) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reach_cand20", int'(kif.cand), 20);
    check("abort_pre_count", int'(kif.feas_count), 20);
    kif.abort = 1'b1;
    @(negedge clk);
    kif.abort = 1'b0;
    check("abort_busy", int'(kif.busy), 0);
    check("abort_done", int'(kif.done), 0);
    check("abort_results", results_packed(), 0);
    @(negedge clk);
    check("abort_no_late_done", int'(kif.done), 0);
    run_scan("after_abort", 1, 1'b0, 1'b0, 0, 1, 0, 5, 64, 65);

    // Reset held two cycles in the middle of a scan
    mode = 1;
    @(negedge clk);
    kif.start = 1'b1;
    @(negedge clk);
    kif.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    saw_done = 0;
    @(negedge clk);
    check("midscan_reset_1", outs_packed(), 0);
    @(negedge clk);
    check("midscan_reset_2", outs_packed(), 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (kif.done || kif.busy) saw_done++;
    end
    check("post_reset_quiet", saw_done, 0);
    check("post_reset_outputs", outs_packed(), 0);
    run_scan("after_reset", 0, 1'b0, 1'b0, 0, 1, 30, 15, 1, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/knapsack_search_ctrl.md
# knapsack_search_ctrl

Sequencing controller that exhaustively enumerates every item-selection mask for the N-item knapsack constraint checker. It also selects the best feasible selection. The controller drives one candidate mask per cycle into the external combinational checker and samples the checker's feasibility flag and total value in the same cycle. It tracks the highest-value feasible mask and the count of feasible masks, then signals completion. It sits between the system sequencer (start/done handshake) and the checker datapath.

## Interface

Parameters:
- N_ITEMS, 6, number of items; candidate mask width, 2^N_ITEMS masks scanned.
- VAL_W, 6, width of checker value input and best_value output.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a scan; honoured only in IDLE.
- abort  in  1  terminate an in-progress scan.
- first_only  in  1  sampled with start; 1 = stop at first feasible mask.
- cand  out  N_ITEMS  candidate mask to checker; bit 0 = item A, bit N_ITEMS-1 = last item.
- chk_valid  in  1  checker feasibility for current cand (combinational).
- chk_value  in  VAL_W  checker total value for current cand.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse on scan completion.
- found  out  1  at least one feasible mask seen in last scan.
- best_mask  out  N_ITEMS  highest-value feasible mask.
- best_value  out  VAL_W  its value.
- feas_count  out  N_ITEMS+1  number of feasible masks seen.

## Operation

- States: IDLE, SCAN, DONE.
- Reset (rst_n=0 at an edge): state IDLE; cand, busy, done, found, best_mask, best_value, feas_count all 0; latched first_only 0.
- IDLE:
  - start=1 → SCAN, cand←0, found/best_mask/best_value/feas_count←0, latch first_only.
  - Results from the previous scan are held until the next start.
- SCAN, per cycle, for the current cand:
  - If chk_valid and (found=0 or chk_value > best_value): best_mask←cand, best_value←chk_value, found←1. The comparison is strict unsigned, so ties keep the lower mask.
  - If chk_valid: feas_count←feas_count+1. N_ITEMS+1 bits hold 2^N_ITEMS, so there is no overflow.
  - If cand = 2^N_ITEMS−1, or (latched first_only and chk_valid): → DONE, cand unchanged. Otherwise cand←cand+1.
- DONE: done=1 for exactly one cycle → IDLE. cand returns to 0 in IDLE.
- abort=1 in SCAN:
  - → IDLE next edge, done not pulsed.
  - found, best_mask, best_value and feas_count clear to 0.
  - The sample in the abort cycle is discarded.
- abort in IDLE/DONE: no effect. DONE still pulses.
- start while busy or in DONE: ignored.
- start and abort together in IDLE: start wins.
- Reset mid-scan: the reset values above apply on that edge. No done pulse.

## Timing

- start sampled at edge T0 → busy=1 and cand=0 from T0+1.
- Full scan: cand=k visible during cycle T0+1+k, k=0..2^N_ITEMS−1. It is sampled at the edge ending that cycle.
- done=1 during cycle T0+2^N_ITEMS+1; busy=0 in that cycle. Back in IDLE at T0+2^N_ITEMS+2. For N_ITEMS=6: 64 scan cycles, done at T0+65.
- first_only with first feasible mask m: done during cycle T0+m+2.
- Results are stable from the done cycle onward until the next accepted start.
- The checker path (cand → chk_valid/chk_value → best registers) must close in one cycle. No pipeline stage is inserted.

## Test plan

- Reset: assert rst_n=0 for 2 cycles mid-scan → all outputs 0, state IDLE, no done pulse.
- Production triple-constraint checker, constants:
  - item values 4,2,2,1,10,20; weights 12,1,2,1,4,1; volumes 10,2,1,4,3,12; costs 3,2,1,3,2,1.
  - limits: min value 15, max weight 16, max volume 10, max cost 10.
  - Stimulus: start (first_only=0) → done at T0+65, found=1, best_mask=6'b011110 (30), best_value=15, feas_count=1.
- Same checker with first_only=1 → done at T0+32, best_mask=30, feas_count=1.
- Stub checker, chk_valid=1 for all masks, chk_value=5 constant → best_mask=0 (tie rule), feas_count=64. Stub always invalid → found=0, best_value=0, feas_count=0, done at T0+65.
- abort asserted while cand=20 → busy falls next cycle, no done pulse, results 0. A start issued 2 cycles later restarts at cand=0 and completes normally.
- start pulsed at T0+10 during a scan → ignored; done still at T0+65 with a single done pulse.
